// File: rtl/ahb3lite_pkg.sv
// Shared AHB-Lite definitions for the slave-side bus mux.
//   htrans_t   : master transfer type encoding
//   OKAY/ERROR : HRESP encodings
//   ds_state_t : default-slave response states
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic OKAY  = 1'b0;
  localparam logic ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

endpackage

// File: rtl/ahb3lite_default_slave.sv
// Default slave for unmapped address regions. Answers IDLE/BUSY with a
// zero-wait OKAY and NONSEQ/SEQ with the two-cycle ERROR response, and
// counts ERROR responses in a saturating counter.
// Ports:
//   HCLK, HRESET   clock, synchronous active-high reset
//   active         current address phase targets an unmapped region
//   HREADY         bus HREADY (address phase is accepted when high)
//   HTRANS         master transfer type
//   ds_hready      default-slave ready
//   ds_hresp       default-slave response
//   ERR_CNT        saturating count of ERROR responses
module ahb3lite_default_slave
  import ahb3lite_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             active,
  input  logic             HREADY,
  input  logic [1:0]       HTRANS,
  output logic             ds_hready,
  output logic             ds_hresp,
  output logic [CNT_W-1:0] ERR_CNT
);

  ds_state_t state, state_nxt;
  logic      err_start;

  assign err_start = HREADY && active && (HTRANS == NONSEQ || HTRANS == SEQ);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= DS_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DS_IDLE: if (err_start) state_nxt = DS_ERR1;
      DS_ERR1: state_nxt = DS_ERR2;
      DS_ERR2: state_nxt = err_start ? DS_ERR1 : DS_IDLE;
      default: state_nxt = DS_IDLE;
    endcase
  end

  // Outputs decode from state alone so bus HREADY never loops back
  // through the next-state logic.
  assign ds_hready = (state != DS_ERR1);
  assign ds_hresp  = (state == DS_IDLE) ? OKAY : ERROR;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ERR_CNT <= '0;
    end else if (state_nxt == DS_ERR1 && ERR_CNT != '1) begin
      ERR_CNT <= ERR_CNT + 1'b1;
    end
  end

endmodule

// File: rtl/ahb3lite_bus_mux.sv
// AHB-Lite slave-side interconnect: decodes the address phase to a one-hot
// HSEL, registers the selected slave for the data phase, muxes read data
// and responses back to the master, and routes unmapped regions to a
// built-in default slave.
// Ports:
//   HCLK, HRESET                  clock, synchronous active-high reset
//   HADDR, HTRANS                 master address phase
//   HSEL                          one-hot slave select (address phase)
//   HRDATA_S, HRESP_S, HREADYOUT_S  packed slave responses
//   HRDATA, HRESP, HREADY         muxed response to master
//   ERR_CNT                       default-slave ERROR count
module ahb3lite_bus_mux
  import ahb3lite_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_BITS   = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 8
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [ADDR_W-1:0]            HADDR,
  input  logic [1:0]                   HTRANS,
  output logic [NUM_SLAVES-1:0]        HSEL,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]        HRESP_S,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HRESP,
  output logic                         HREADY,
  output logic [CNT_W-1:0]             ERR_CNT
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 2**SEL_BITS) begin : g_bad_num_slaves
    $error("ahb3lite_bus_mux: NUM_SLAVES must be in 1..2**SEL_BITS");
  end

  logic [SEL_BITS-1:0] idx;
  logic                mapped;
  logic                dsel_def;
  logic [SEL_BITS-1:0] dsel_idx;
  logic                ds_hready;
  logic                ds_hresp;
  logic                unused_addr;

  assign idx         = HADDR[ADDR_W-1 -: SEL_BITS];
  assign unused_addr = ^HADDR[ADDR_W-SEL_BITS-1:0];

  always_comb begin
    HSEL = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      HSEL[i] = (idx == SEL_BITS'(i));
    end
  end

  // An index is mapped exactly when it selects one of the slaves.
  assign mapped = |HSEL;

  // Data-phase select: follows the accepted address phase, frozen in waits.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel_def <= 1'b1;
      dsel_idx <= '0;
    end else if (HREADY) begin
      dsel_def <= !mapped;
      dsel_idx <= idx;
    end
  end

  always_comb begin
    HRDATA = '0;
    HRESP  = ds_hresp;
    HREADY = ds_hready;
    if (!dsel_def) begin
      HRESP  = OKAY;
      HREADY = 1'b1;
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (dsel_idx == SEL_BITS'(i)) begin
          HRDATA = HRDATA_S[i*DATA_W +: DATA_W];
          HRESP  = HRESP_S[i];
          HREADY = HREADYOUT_S[i];
        end
      end
    end
  end

  ahb3lite_default_slave #(
    .CNT_W (CNT_W)
  ) u_default_slave (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .active    (!mapped),
    .HREADY    (HREADY),
    .HTRANS    (HTRANS),
    .ds_hready (ds_hready),
    .ds_hresp  (ds_hresp),
    .ERR_CNT   (ERR_CNT)
  );

endmodule

// File: tb/tb_ahb3lite_bus_mux.sv
// Bench for ahb3lite_bus_mux (NUM_SLAVES=3, SEL_BITS=2, CNT_W=2).
// A transaction-level model tracks which slave owns the data phase and how
// many error-response cycles remain; a negedge process compares every cycle.
// Directed stimulus adds hand-computed literal expectations.
module tb_ahb3lite_bus_mux;
  import ahb3lite_pkg::*;

  localparam int NS = 3;
  localparam int SB = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 2;

  logic              HCLK;
  logic              HRESET;
  logic [AW-1:0]     HADDR;
  logic [1:0]        HTRANS;
  logic [NS-1:0]     HSEL;
  logic [NS*DW-1:0]  HRDATA_S;
  logic [NS-1:0]     HRESP_S;
  logic [NS-1:0]     HREADYOUT_S;
  logic [DW-1:0]     HRDATA;
  logic              HRESP;
  logic              HREADY;
  logic [CW-1:0]     ERR_CNT;

  int n_tests = 0;
  int n_fail  = 0;

  ahb3lite_bus_mux #(
    .NUM_SLAVES (NS),
    .SEL_BITS   (SB),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .CNT_W      (CW)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HSEL        (HSEL),
    .HRDATA_S    (HRDATA_S),
    .HRESP_S     (HRESP_S),
    .HREADYOUT_S (HREADYOUT_S),
    .HRDATA      (HRDATA),
    .HRESP       (HRESP),
    .HREADY      (HREADY),
    .ERR_CNT     (ERR_CNT)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // m_owner: slave owning the data phase, -1 = default slave.
  // m_err_left: error-response cycles still to show (2 = wait, 1 = final).
  int m_owner    = -1;
  int m_err_left = 0;
  int m_cnt      = 0;
  bit m_valid    = 1'b0;

  function automatic logic [DW+1:0] exp_out();
    logic [DW-1:0] d;
    logic          rsp;
    logic          rdy;
    if (m_owner >= 0) begin
      d   = HRDATA_S[m_owner*DW +: DW];
      rsp = HRESP_S[m_owner];
      rdy = HREADYOUT_S[m_owner];
    end else begin
      d   = '0;
      rsp = (m_err_left != 0);
      rdy = (m_err_left != 2);
    end
    return {d, rsp, rdy};
  endfunction

  function automatic logic [NS-1:0] exp_hsel();
    int r;
    r = int'(HADDR[AW-1 -: SB]);
    return (r < NS) ? NS'(1 << r) : '0;
  endfunction

  always @(posedge HCLK) begin
    logic [DW+1:0] o;
    int            r;
    if (HRESET) begin
      m_owner    = -1;
      m_err_left = 0;
      m_cnt      = 0;
      m_valid    = 1'b1;
    end else if (m_valid) begin
      o = exp_out();
      r = int'(HADDR[AW-1 -: SB]);
      if (m_err_left == 2) begin
        m_err_left = 1;
      end else if (o[0]) begin
        if (r < NS) begin
          m_owner    = r;
          m_err_left = 0;
        end else begin
          m_owner = -1;
          if (HTRANS[1]) begin
            m_err_left = 2;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
          end else begin
            m_err_left = 0;
          end
        end
      end
    end
  end

  always @(negedge HCLK) begin
    logic [DW+1:0] o;
    if (m_valid) begin
      o = exp_out();
      chk("model_hsel",   HSEL,    exp_hsel());
      chk("model_hrdata", HRDATA,  o[DW+1:2]);
      chk("model_hresp",  HRESP,   o[1]);
      chk("model_hready", HREADY,  o[0]);
      chk("model_errcnt", ERR_CNT, m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge HCLK);
    #2;
  endtask

  task automatic drive(input logic [AW-1:0] a, input logic [1:0] t);
    HADDR  = a;
    HTRANS = t;
    #1;
  endtask

  int exp_cnt[4] = '{1, 2, 3, 3};

  initial begin
    HRESET      = 1'b1;
    HADDR       = '0;
    HTRANS      = IDLE;
    HRESP_S     = '0;
    HREADYOUT_S = '1;
    HRDATA_S    = {32'hCAFE_2222, 32'hDEAD_BEEF, 32'h1111_0000};

    // Reset for two cycles
    tick();
    tick();
    HRESET = 1'b0;
    #1;
    chk("rst_hready", HREADY, 1);
    chk("rst_hresp",  HRESP, 0);
    chk("rst_hrdata", HRDATA, 0);
    chk("rst_errcnt", ERR_CNT, 0);

    // Zero-wait read from slave 1
    drive(32'h4000_0010, NONSEQ);
    chk("s1_hsel", HSEL, 3'b010);
    tick();
    drive(32'h0000_0000, IDLE);
    chk("s1_hrdata", HRDATA, 32'hDEAD_BEEF);
    chk("s1_hresp",  HRESP, 0);
    chk("s1_hready", HREADY, 1);
    tick();

    // Slave 1 inserts two wait states while slave 2 address is pending
    drive(32'h4000_0000, NONSEQ);
    tick();
    HREADYOUT_S[1] = 1'b0;
    drive(32'h8000_0000, NONSEQ);
    chk("wait1_hready", HREADY, 0);
    chk("wait1_hrdata", HRDATA, 32'hDEAD_BEEF);
    tick();
    drive(32'h0000_0004, NONSEQ);
    chk("wait2_hready", HREADY, 0);
    chk("wait2_hrdata", HRDATA, 32'hDEAD_BEEF);
    tick();
    HREADYOUT_S[1] = 1'b1;
    drive(32'h8000_0000, NONSEQ);
    chk("wait_end_hready", HREADY, 1);
    tick();
    drive(32'h0000_0000, IDLE);
    chk("s2_hrdata", HRDATA, 32'hCAFE_2222);
    tick();

    // Unmapped NONSEQ: two-cycle ERROR
    drive(32'hC000_0000, NONSEQ);
    chk("unm_hsel", HSEL, 3'b000);
    tick();
    drive(32'h0000_0000, IDLE);
    chk("err1_hready", HREADY, 0);
    chk("err1_hresp",  HRESP, 1);
    tick();
    drive(32'hC000_0000, IDLE);
    chk("err2_hready", HREADY, 1);
    chk("err2_hresp",  HRESP, 1);
    chk("err2_errcnt", ERR_CNT, 1);
    tick();
    drive(32'h0000_0000, IDLE);
    chk("unm_idle_hready", HREADY, 1);
    chk("unm_idle_hresp",  HRESP, 0);
    chk("unm_idle_errcnt", ERR_CNT, 1);
    tick();

    // Back-to-back unmapped NONSEQ with counter saturation (cleared first)
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(32'hC000_0000, NONSEQ);
      if (k > 0) begin
        chk("b2b_err2_hready", HREADY, 1);
        chk("b2b_err2_hresp",  HRESP, 1);
      end
      tick();
      drive(32'hC000_0000, NONSEQ);
      chk("b2b_err1_hready", HREADY, 0);
      chk("b2b_err1_hresp",  HRESP, 1);
      chk("b2b_errcnt",      ERR_CNT, exp_cnt[k]);
      tick();
    end
    drive(32'h0000_0000, IDLE);
    chk("b2b_last_hready", HREADY, 1);
    chk("b2b_last_hresp",  HRESP, 1);
    chk("b2b_last_errcnt", ERR_CNT, 3);
    tick();

    // Reset during the wait cycle of an ERROR response
    drive(32'hC000_0000, NONSEQ);
    tick();
    HRESET = 1'b1;
    drive(32'h0000_0000, IDLE);
    chk("rst_err1_hready", HREADY, 0);
    tick();
    HRESET = 1'b0;
    #1;
    chk("rst_mid_hready", HREADY, 1);
    chk("rst_mid_hresp",  HRESP, 0);
    chk("rst_mid_hrdata", HRDATA, 0);
    chk("rst_mid_errcnt", ERR_CNT, 0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
